// File: rtl/fp32_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp32_div_seq
// Description : Iterative IEEE-754 single-precision divider, result = a / b.
//               A radix-2 restoring mantissa divider produces one quotient
//               bit per clock under control of a small FSM. Operands are
//               captured on an accepted start; the result is reported with a
//               one-cycle valid pulse after a fixed latency, independent of
//               operand class.
//
//               Denormal inputs are flushed to zero and no denormal results
//               are produced (underflow goes to signed zero). Rounding is
//               round-to-nearest-even.
//
// Ports       : clk         - rising-edge clock
//               rst         - synchronous active-high reset
//               start       - request, sampled only while ready = 1
//               a, b        - dividend / divisor (IEEE-754 single)
//               ready       - high only while idle
//               valid       - one-cycle pulse, result is final
//               result      - quotient, held until the next valid
//               div_by_zero - finite nonzero / zero, held like result
//
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ready,
    output logic        valid,
    output logic [31:0] result,
    output logic        div_by_zero
);

    // 24 mantissa bits + 1 normalisation bit + guard + round
    localparam int QBITS = 27;

    localparam logic [4:0]  c_last_step = 5'(QBITS - 1);
    localparam logic [31:0] c_qnan      = 32'h7FC0_0000;

    // Special-case result classes decided at unpack time
    localparam logic [1:0] c_spec_none = 2'd0;
    localparam logic [1:0] c_spec_nan  = 2'd1;
    localparam logic [1:0] c_spec_inf  = 2'd2;
    localparam logic [1:0] c_spec_zero = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DIV   = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // ------------------------------------------------------------------
    // Registered datapath state
    // ------------------------------------------------------------------
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic              r_sign;
    logic signed [9:0] r_exp;       // ea - eb, bias added after normalisation
    logic [1:0]        r_spec;
    logic              r_dbz;
    logic [24:0]       r_rem;       // partial remainder
    logic [23:0]       r_mb;        // divisor mantissa
    logic [QBITS-1:0]  r_q;         // quotient, shifted in MSB first
    logic [4:0]        r_cnt;
    logic [31:0]       r_result;
    logic              r_dbz_out;

    // ------------------------------------------------------------------
    // Unpack of the latched operands (used in LOAD)
    // ------------------------------------------------------------------
    logic [7:0]  w_ea;
    logic [7:0]  w_eb;
    logic        w_a_zero;
    logic        w_b_zero;
    logic        w_a_inf;
    logic        w_b_inf;
    logic        w_a_nan;
    logic        w_b_nan;
    logic [23:0] w_ma;
    logic [23:0] w_mb;
    logic [1:0]  w_spec;
    logic        w_dbz;

    assign w_ea     = r_a[30:23];
    assign w_eb     = r_b[30:23];
    // Exponent field 0 covers both true zero and flushed denormals
    assign w_a_zero = (w_ea == 8'h00);
    assign w_b_zero = (w_eb == 8'h00);
    assign w_a_inf  = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
    assign w_b_inf  = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);
    assign w_a_nan  = (w_ea == 8'hFF) && (r_a[22:0] != 23'd0);
    assign w_b_nan  = (w_eb == 8'hFF) && (r_b[22:0] != 23'd0);
    assign w_ma     = w_a_zero ? 24'd0 : {1'b1, r_a[22:0]};
    assign w_mb     = w_b_zero ? 24'd0 : {1'b1, r_b[22:0]};

    // Special cases in priority order
    always_comb begin
        w_spec = c_spec_none;
        w_dbz  = 1'b0;
        if (w_a_nan || w_b_nan) begin
            w_spec = c_spec_nan;
        end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec = c_spec_nan;
        end else if (w_a_inf) begin
            w_spec = c_spec_inf;
        end else if (w_b_inf) begin
            w_spec = c_spec_zero;
        end else if (w_b_zero) begin
            w_spec = c_spec_inf;
            w_dbz  = 1'b1;
        end else if (w_a_zero) begin
            w_spec = c_spec_zero;
        end
    end

    // ------------------------------------------------------------------
    // One restoring step
    // ------------------------------------------------------------------
    logic [25:0] w_trial;
    logic        w_qbit;
    logic [24:0] w_rem_keep;

    assign w_trial    = {1'b0, r_rem} - {2'b00, r_mb};
    assign w_qbit     = ~w_trial[25];
    assign w_rem_keep = w_qbit ? w_trial[24:0] : r_rem;

    // ------------------------------------------------------------------
    // Normalise, round, pack, override
    // ------------------------------------------------------------------
    logic              w_norm;
    logic [23:0]       w_mant;
    logic              w_guard;
    logic              w_round;
    logic              w_sticky;
    logic              w_round_up;
    logic [24:0]       w_mant_r;
    logic signed [9:0] w_exp_pre;
    logic signed [9:0] w_exp_fin;
    logic [31:0]       w_packed;
    logic [31:0]       w_final;

    // Quotient lies in [2^25, 2^27): the MSB tells which window holds
    // the 24-bit mantissa.
    assign w_norm    = r_q[QBITS-1];
    assign w_mant    = w_norm ? r_q[26:3] : r_q[25:2];
    assign w_guard   = w_norm ? r_q[2]    : r_q[1];
    assign w_round   = w_norm ? r_q[1]    : r_q[0];
    assign w_sticky  = (w_norm && r_q[0]) || (r_rem != 25'd0);
    assign w_exp_pre = r_exp + (w_norm ? 10'sd127 : 10'sd126);

    // Nearest-even: above halfway, or exactly halfway with odd LSB
    assign w_round_up = w_guard && (w_round || w_sticky || w_mant[0]);
    assign w_mant_r   = {1'b0, w_mant} + {24'd0, w_round_up};
    // Carry-out leaves the mantissa as 1.000..0, so the fraction field is
    // zero either way; only the exponent needs the bump.
    assign w_exp_fin  = w_exp_pre + $signed({9'd0, w_mant_r[24]});

    always_comb begin
        w_packed = {r_sign, w_exp_fin[7:0], w_mant_r[22:0]};
        if (w_exp_fin >= 10'sd255) begin
            w_packed = {r_sign, 8'hFF, 23'd0};
        end else if (w_exp_fin <= 10'sd0) begin
            w_packed = {r_sign, 31'd0};
        end
    end

    always_comb begin
        w_final = w_packed;
        case (r_spec)
            c_spec_nan:  w_final = c_qnan;
            c_spec_inf:  w_final = {r_sign, 8'hFF, 23'd0};
            c_spec_zero: w_final = {r_sign, 31'd0};
            default:     w_final = w_packed;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        valid        = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next_state = S_DIV;
            end
            S_DIV: begin
                if (r_cnt == c_last_step) begin
                    w_next_state = S_ROUND;
                end
            end
            S_ROUND: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                valid        = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_sign    <= 1'b0;
            r_exp     <= 10'sd0;
            r_spec    <= c_spec_none;
            r_dbz     <= 1'b0;
            r_rem     <= 25'd0;
            r_mb      <= 24'd0;
            r_q       <= '0;
            r_cnt     <= 5'd0;
            r_result  <= 32'd0;
            r_dbz_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a <= a;
                        r_b <= b;
                    end
                end
                S_LOAD: begin
                    r_sign <= r_a[31] ^ r_b[31];
                    r_exp  <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb});
                    r_spec <= w_spec;
                    r_dbz  <= w_dbz;
                    r_rem  <= {1'b0, w_ma};
                    r_mb   <= w_mb;
                    r_q    <= '0;
                    r_cnt  <= 5'd0;
                end
                S_DIV: begin
                    // Kept remainder is below the divisor, so the shifted
                    // value still fits in 25 bits.
                    r_rem <= {w_rem_keep[23:0], 1'b0};
                    r_q   <= {r_q[QBITS-2:0], w_qbit};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_ROUND: begin
                    r_result  <= w_final;
                    r_dbz_out <= r_dbz;
                end
                default: begin
                end
            endcase
        end
    end

    assign result      = r_result;
    assign div_by_zero = r_dbz_out;

endmodule
`default_nettype wire

// File: tb/tb_fp32_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_div_seq
// Description : Directed self-checking bench for fp32_div_seq. Each vector
//               carries a hand-computed quotient; latency, handshake,
//               result hold and mid-operation reset are checked as well.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_div_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        valid;
    logic [31:0] result;
    logic        div_by_zero;

    int          n_total;
    int          n_bad;
    logic [31:0] r_prev;

    fp32_div_seq u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .valid       (valid),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    // Issue one operation from the idle state (called #1 after an edge)
    // and check latency, result, flag and result hold while busy.
    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic [31:0] er, input logic edz, input bit noise);
        int  n;
        int  extra;
        bit  seen;
        a     = ta;
        b     = tb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h3F80_0000;
        chk({tag, "_busy"}, {31'd0, ready}, 32'd0);
        n    = 1;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (noise && (n == 5 || n == 20)) begin
                start = 1'b1;
                a     = 32'h3F80_0000;
                b     = 32'h4000_0000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (valid) begin
                seen = 1'b1;
            end else if (n == 15) begin
                chk({tag, "_hold"}, result, r_prev);
            end
        end
        start = 1'b0;
        chk({tag, "_lat"}, n, 30);
        chk({tag, "_res"}, result, er);
        chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edz});
        r_prev = er;
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {31'd0, valid}, 32'd0);
        if (noise) begin
            extra = 0;
            for (int i = 0; i < 35; i++) begin
                @(posedge clk); #1;
                if (valid || !ready) extra++;
            end
            chk({tag, "_ignored"}, extra, 0);
            chk({tag, "_res_kept"}, result, er);
        end
    endtask

    initial begin
        int busy_valid;
        n_total = 0;
        n_bad   = 0;
        r_prev  = 32'd0;
        rst     = 1'b1;
        start   = 1'b0;
        a       = 32'd0;
        b       = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // basic, with ignored starts at busy cycles 5 and 20
        do_op("nine_by_4p5", 32'h4110_0000, 32'h4090_0000, 32'h4000_0000, 1'b0, 1'b1);
        // back-to-back: issued in the cycle after DONE
        do_op("third",       32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0);
        do_op("third_b2b",   32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0);
        do_op("neg15_by_5",  32'hC170_0000, 32'h40A0_0000, 32'hC040_0000, 1'b0, 1'b0);
        do_op("neg_one",     32'hC12A_6666, 32'h412A_6666, 32'hBF80_0000, 1'b0, 1'b0);
        do_op("div_zero",    32'h40A0_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b0);
        do_op("zero_zero",   32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0);
        do_op("inf_by_2",    32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, 1'b0);
        do_op("two_by_inf",  32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b0);
        do_op("nan_in",      32'h7FC0_1234, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0);
        do_op("overflow",    32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0, 1'b0);
        do_op("underflow",   32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
        do_op("denorm_in",   32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0);

        // reset during DIV cycle 10
        a     = 32'h3F80_0000;
        b     = 32'h4040_0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_result", result, 32'd0);
        busy_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid) busy_valid++;
        end
        chk("abort_no_valid", busy_valid, 0);
        r_prev = 32'd0;
        do_op("after_abort", 32'h4110_0000, 32'h4090_0000, 32'h4000_0000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp32_div_seq.md
Name: fp32_div_seq

Overview:
- Iterative IEEE-754 single-precision divider, result = a / b.
- Counterpart of the combinational adder and multiplier in the FP unit; division is the inverse of the multiplier.
- Uses a radix-2 restoring mantissa divider driven by an FSM, with a start/ready/valid handshake, so it can sit behind the same operand registers as the add/mul datapath.

Parameters:
- QBITS, 27, quotient bits produced by the divide loop: 24 mantissa + 1 normalisation + guard + round. Fixed; not for user override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when ready=1.
- a  in  32  dividend, IEEE-754 single; captured on an accepted start.
- b  in  32  divisor, IEEE-754 single; captured on an accepted start.
- ready  out  1  high only in IDLE.
- valid  out  1  one-cycle pulse; result is final.
- result  out  32  quotient; holds its value until the next valid.
- div_by_zero  out  1  set with valid when b=±0 and a is finite and nonzero; holds like result.

Behaviour:
- Reset: state=IDLE, ready=1, valid=0, result=32'h0, div_by_zero=0. rst overrides everything, including mid-operation: the operation is aborted, with no valid and no stale result.
- States:
  - IDLE: start=1 → LOAD. Latch a and b.
  - LOAD: unpack; go to DIV.
    - Exponent field 0 is treated as zero (denormal inputs are flushed); mantissa = {1, frac} otherwise.
    - sign = a[31]^b[31]. Set the special-case flags.
  - DIV: one restoring step per cycle, exactly QBITS cycles.
    - rem = {ma, pad} initially. Each step: trial = rem - mb; if trial ≥ 0 then q bit = 1 and rem = trial; shift.
  - ROUND: normalise, round, pack, then apply special-case overrides.
  - DONE: valid=1 for this single cycle; next edge → IDLE.
- Latency: fixed for every operand class, including specials. valid is high in the cycle after the 30th rising edge counted from the edge that sampled start. Back-to-back: the next start can be accepted in the cycle after DONE.
- start while ready=0 is ignored and not queued. Operand changes after acceptance have no effect.
- Normalisation:
  - Quotient MSB = 1 (ma ≥ mb): use bits [26:3], guard = [2], round = [1]; exp = ea - eb + 127.
  - Otherwise: use bits [25:2]; exp = ea - eb + 126.
  - sticky = OR of the remaining quotient bits | (rem ≠ 0).
- Rounding: round-to-nearest-even on guard/round/sticky. A mantissa carry-out increments exp.
- Exponent: computed in 10-bit signed.
  - exp ≥ 255 → ±Inf (sign, 8'hFF, 0).
  - exp ≤ 0 → ±0; no denormal outputs.
- Specials, in priority order:
  - a or b NaN → 32'h7FC00000.
  - 0/0 or Inf/Inf → 32'h7FC00000.
  - Inf/finite → ±Inf.
  - finite/Inf → ±0.
  - finite≠0 / 0 → ±Inf, div_by_zero=1.
  - 0/finite → ±0.
- div_by_zero is 0 for every other case, including NaN results.

Test Plan:
- a=41100000 (9), b=40900000 (4.5), start → ready drops; valid exactly 30 edges later; result=40000000, div_by_zero=0.
- a=3F800000, b=40400000 (1/3) → 3EAAAAAB (rounding up); a=C1700000, b=40A00000 (-15/5) → C0400000; a=C12A6666, b=412A6666 → BF800000.
- a=40A00000, b=00000000 → 7F800000, div_by_zero=1. a=00000000, b=00000000 → 7FC00000, div_by_zero=0. a=7F800000, b=40000000 → 7F800000.
- Overflow: a=7F000000, b=3E800000 → 7F800000. Underflow: a=00800000, b=40000000 → 00000000. Denormal input a=00000001, b=3F800000 → 00000000.
- Handshake: pulse start again at cycles 5 and 20 of a busy operation → ignored, exactly one valid pulse. Issue a new start the cycle after DONE → accepted, and result holds its old value until the new valid.
- Reset mid-operation: assert rst at DIV cycle 10 → next cycle ready=1, valid=0, result=0. No valid pulse for the aborted operation, and a following 9/4.5 still yields 40000000.
